// File: rtl/mem_store_sink.sv
// Store sink for a core's memory stage: counts stores, latches the first tohost result,
// and (with STORE_LOG_EN defined) logs non-tohost stores into a FIFO.
module mem_store_sink #(
   parameter int          DEPTH       = 8,
   parameter logic [31:0] TOHOST_ADDR = 32'd100,
   parameter logic [31:0] PASS_VALUE  = 32'd25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_write,
   input  logic [31:0] data_addr_m,
   input  logic [31:0] write_data_m,
   output logic        log_valid,
   input  logic        log_ready,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   output logic        done,
   output logic        pass,
   output logic [31:0] store_count,
   output logic [15:0] drop_count
);

   logic        is_tohost;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [31:0] store_count_q, store_count_d;

   assign is_tohost = mem_write && (data_addr_m == TOHOST_ADDR);

   always_comb begin
      done_d        = done_q;
      pass_d        = pass_q;
      store_count_d = store_count_q;
      if (mem_write) begin
         store_count_d = store_count_q + 32'd1;
         // Only the first tohost store decides the verdict.
         if (is_tohost && !done_q) begin
            done_d = 1'b1;
            pass_d = (write_data_m == PASS_VALUE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         store_count_q <= 32'd0;
      end else begin
         done_q        <= done_d;
         pass_q        <= pass_d;
         store_count_q <= store_count_d;
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign store_count = store_count_q;

`ifdef STORE_LOG_EN
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0]   addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   drop_q, drop_d;
   logic          valid_q, valid_d;
   logic          push_req, push, pop, full;

   assign push_req = mem_write && !is_tohost;
   assign pop      = valid_q && log_ready;
   assign full     = (count_q == FULL_CNT);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push     = push_req && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
      if (push_req && !push && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 16'd0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         valid_q  <= valid_d;
      end
   end

   // Entry storage carries no reset; contents are meaningless while log_valid is low.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= data_addr_m;
         data_mem[wr_ptr_q] <= write_data_m;
      end
   end

   assign log_valid  = valid_q;
   assign log_addr   = addr_mem[rd_ptr_q];
   assign log_data   = data_mem[rd_ptr_q];
   assign drop_count = drop_q;
`else
   logic unused_log_ready;
   assign unused_log_ready = log_ready;
   assign log_valid  = 1'b0;
   assign log_addr   = 32'd0;
   assign log_data   = 32'd0;
   assign drop_count = 16'd0;
`endif

endmodule

// File: doc/mem_store_sink.md
MEM_STORE_SINK -- requirements
Module: mem_store_sink

Interface
REQ-001 Parameter DEPTH, 8, log FIFO entries; power of two, 2..64.
REQ-002 Parameter TOHOST_ADDR, 32'd100, store address that ends the test.
REQ-003 Parameter PASS_VALUE, 32'd25, data at TOHOST_ADDR that signals pass.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 mem_write  in  1  core memory-stage store strobe; one store per cycle high.
REQ-007 data_addr_m  in  32  store byte address, valid when mem_write=1.
REQ-008 write_data_m  in  32  store data, valid when mem_write=1.
REQ-009 log_valid  out  1  log FIFO head entry available.
REQ-010 log_ready  in  1  consumer accepts head entry this cycle.
REQ-011 log_addr  out  32  head entry address.
REQ-012 log_data  out  32  head entry data.
REQ-013 done  out  1  sticky; first TOHOST_ADDR store seen.
REQ-014 pass  out  1  sticky; first TOHOST_ADDR store carried PASS_VALUE.
REQ-015 store_count  out  32  total accepted stores, wraps modulo 2^32.
REQ-016 drop_count  out  16  stores lost to full FIFO, saturates at 16'hFFFF.

Function
REQ-017 Store accepted on any rising edge with mem_write=1; no backpressure to the core, no stall.
REQ-018 Each accepted store increments store_count by 1, TOHOST stores included.
REQ-019 Accepted store with data_addr_m==TOHOST_ADDR while done=0: done<=1, pass<=(write_data_m==PASS_VALUE); both visible the following cycle.
REQ-020 TOHOST stores while done=1 leave done/pass unchanged (first one wins); still counted.
REQ-021 TOHOST stores are not pushed to the log FIFO; all other accepted stores push {addr,data}.
REQ-022 FIFO: registered storage, read and write pointers, occupancy counter 0..DEPTH; pointers wrap DEPTH-1 -> 0.
REQ-023 Pop occurs when log_valid=1 and log_ready=1; log_addr/log_data hold stable while log_valid=1 and log_ready=0.
REQ-024 log_valid = (occupancy != 0); first push into empty FIFO gives log_valid=1 the next cycle (no same-cycle bypass).
REQ-025 Push and pop same cycle with 0<occupancy<DEPTH: occupancy unchanged, both take effect.
REQ-026 Push while full with no pop: entry discarded, drop_count +1 (saturating), FIFO contents unchanged.
REQ-027 Push while full with pop same cycle: push accepted, no drop.
REQ-028 Pop while empty: ignored, no pointer change.
REQ-029 Outputs are register-driven, except log_addr/log_data, which are a direct read of the head storage entry.

Reset
REQ-030 rst=0 asynchronously clears: pointers, occupancy, done, pass, store_count, drop_count; log_valid=0 immediately.
REQ-031 FIFO storage is not reset; log_addr/log_data are don't-care while log_valid=0.
REQ-032 Reset asserted mid-operation discards all buffered entries; first accepted store after deassertion is handled as after power-up.

Configuration
REQ-033 Macro STORE_LOG_EN: defined -> log FIFO, drop_count and REQ-021..028 implemented as above.
REQ-034 STORE_LOG_EN undefined -> no FIFO storage; log_valid, log_addr, log_data, drop_count tied to 0; log_ready ignored; done, pass, store_count unchanged.

Verification
REQ-035 Reset, then store addr=100 data=25 -> next cycle done=1, pass=1, store_count=1, log_valid=0.
REQ-036 Store addr=100 data=7, then addr=100 data=25 -> done=1, pass=0 stays; store_count=2.
REQ-037 DEPTH=8, log_ready=0, 10 stores to addr 0x40+4i, data i -> log_valid=1, drop_count=2; drain yields addr 0x40..0x5C, data 0..7 in order.
REQ-038 FIFO full, store + log_ready=1 same cycle -> drop_count unchanged, occupancy stays 8, new entry read out last.
REQ-039 Pull rst low mid-burst with 3 entries buffered -> log_valid=0 at once, counters 0; after release, one store at 0x80 -> log_addr=0x80, store_count=1.
REQ-040 STORE_LOG_EN undefined, 5 stores to addr 0x20 -> log_valid=0, drop_count=0, store_count=5.
